fifo_rd_ctrl: RTL

- Read-side controller for the 4-entry register FIFO. It is the counterpart of the write-enable decode on the write side.
- Owns the 3-bit read pointer (bit 2 is the wrap bit) and compares it with the writer's pointer to produce empty, full and occupancy.
- Selects and registers the head entry on a pop, and flags illegal requests.
- Sits between the FIFO storage array and the downstream consumer.

---
 rtl/fifo_rd_ctrl.sv | 72 +++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for the 4-entry register FIFO: owns the read pointer,
// derives empty/full/occupancy from the writer's pointer, and registers the popped head.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_req,
  input  logic [2:0]            wr_ptr_curr,
  input  logic [DATA_WIDTH-1:0] entry0,
  input  logic [DATA_WIDTH-1:0] entry1,
  input  logic [DATA_WIDTH-1:0] entry2,
  input  logic [DATA_WIDTH-1:0] entry3,
  output logic [2:0]            rd_ptr_curr,
  output logic [3:0]            rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  empty,
  output logic                  full,
  output logic [2:0]            count,
  output logic                  err
);

  logic [2:0]            diff;
  logic                  illegal;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  // A 4-deep FIFO can never be more than 4 ahead, so differences 5..7 mean corrupted pointers.
  assign diff    = wr_ptr_curr - rd_ptr_curr;
  assign illegal = diff[2] && (diff[1:0] != 2'b00);

  assign count = illegal ? 3'd0 : diff;
  assign empty = !illegal && (wr_ptr_curr == rd_ptr_curr);
  assign full  = !illegal && (wr_ptr_curr[1:0] == rd_ptr_curr[1:0])
                          && (wr_ptr_curr[2] != rd_ptr_curr[2]);

  assign pop = rst_n && rd_req && !empty && !illegal;

  always_comb begin
    head = entry0;
    case (rd_ptr_curr[1:0])
      2'd0: head = entry0;
      2'd1: head = entry1;
      2'd2: head = entry2;
      2'd3: head = entry3;
      default: head = entry0;
    endcase
  end

  always_comb begin
    rd_en = 4'b0000;
    if (pop) rd_en[rd_ptr_curr[1:0]] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_curr <= 3'b000;
      data_out    <= '0;
      data_valid  <= 1'b0;
      err         <= 1'b0;
    end else begin
      data_valid <= pop;
      err        <= (rd_req && empty) || illegal;
      if (pop) begin
        data_out    <= head;
        rd_ptr_curr <= rd_ptr_curr + 3'd1;
      end
    end
  end

endmodule
